// File: rtl/ke11e_pkg.sv
// Shared encodings for the KE11-E EIS step sequencer: op codes, DR select,
// ALU function and the sequencer state enum.
package ke11e_pkg;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_ASH  = 2'd2;
    localparam logic [1:0] OP_ASHC = 2'd3;

    localparam logic [1:0] SDR_HOLD  = 2'b00;
    localparam logic [1:0] SDR_RIGHT = 2'b01;
    localparam logic [1:0] SDR_LEFT  = 2'b10;
    localparam logic [1:0] SDR_LOAD  = 2'b11;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OVF_WAIT,
        ST_ITER,
        ST_FIXUP,
        ST_FLAGS,
        ST_DONE
    } state_e;

    // ASH and ASHC share the op[1]=1 half of the code space.
    function automatic logic op_is_shift(input logic [1:0] op_in);
        return op_in[1];
    endfunction

endpackage

// File: rtl/ke11e_step_cnt.sv
// Iteration/shift counter: loadable, counts up or down toward zero and never
// steps past zero.
module ke11e_step_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && !zero) begin
            cnt_d = up ? (cnt_q + ONE) : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    // One step away from zero in the current direction.
    assign last = up ? (cnt_q == '1) : (cnt_q == ONE);

endmodule

// File: rtl/ke11e_eis_seq.sv
// KE11-E EIS step sequencer: runs one MUL/DIV/ASH/ASHC command and drives the
// per-cycle DR select, ALU function, BR and flag enables from registered outputs.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | waiting for start
//   ST_LOAD     | DR <- BR, counter loaded, DIV overflow sampled
//   ST_OVF_WAIT | DIV overflow: one quiet cycle before the aborting DONE
//   ST_ITER     | one multiply/divide step or one shift per cycle
//   ST_FIXUP    | DIV remainder correction
//   ST_FLAGS    | EPS flag update
//   ST_DONE     | done strobe (abort with it on DIV overflow)
module ke11e_eis_seq
    import ke11e_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic             dr0,
    input  logic             div_sub,
    input  logic             div_ovf,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [1:0]       sdr,
    output logic [1:0]       alu_fn,
    output logic             clk_br,
    output logic             clk_flags,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(WIDTH);

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;
    logic [1:0] sdr_q, sdr_d;
    logic [1:0] alu_q, alu_d;
    logic       clk_br_q, clk_br_d;
    logic       clk_flags_q, clk_flags_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_up;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             cnt_last;

    assign cnt_load     = (state_q == ST_IDLE) && start;
    assign cnt_load_val = op_is_shift(op) ? shift_cnt : ITER_CNT;
    assign cnt_en       = (state_q == ST_ITER);
    // Negative shift counts step up toward zero; MUL/DIV counts are positive.
    assign cnt_up       = cnt_val[CNT_W-1];

    ke11e_step_cnt #(
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .cnt      (cnt_val),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    op_d    = op;
                end
            end
            ST_LOAD: begin
                if ((op_q == OP_DIV) && div_ovf) begin
                    state_d = ST_OVF_WAIT;
                end else if (op_is_shift(op_q) && cnt_zero) begin
                    state_d = ST_FLAGS;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_OVF_WAIT: state_d = ST_DONE;
            ST_ITER: begin
                if (cnt_last) begin
                    state_d = (op_q == OP_DIV) ? ST_FIXUP : ST_FLAGS;
                end
            end
            ST_FIXUP: state_d = ST_FLAGS;
            ST_FLAGS: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register in
    // step with it; dr0/div_sub therefore act one cycle ahead of their step.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = 1'b0;
        abort_d     = 1'b0;
        sdr_d       = SDR_HOLD;
        alu_d       = ALU_PASS;
        clk_br_d    = 1'b0;
        clk_flags_d = 1'b0;

        case (state_d)
            ST_LOAD: sdr_d = SDR_LOAD;
            ST_ITER: begin
                clk_br_d = 1'b1;
                case (op_q)
                    OP_MUL: begin
                        sdr_d = SDR_RIGHT;
                        alu_d = dr0 ? ALU_ADD : ALU_PASS;
                    end
                    OP_DIV: begin
                        sdr_d = SDR_LEFT;
                        alu_d = div_sub ? ALU_SUB : ALU_ADD;
                    end
                    default: begin
                        sdr_d = cnt_val[CNT_W-1] ? SDR_RIGHT : SDR_LEFT;
                        alu_d = ALU_PASS;
                    end
                endcase
            end
            ST_FIXUP: begin
                clk_br_d = 1'b1;
                alu_d    = div_sub ? ALU_ADD : ALU_PASS;
            end
            ST_FLAGS: clk_flags_d = 1'b1;
            ST_DONE: begin
                done_d  = 1'b1;
                abort_d = (state_q == ST_OVF_WAIT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            sdr_q       <= SDR_HOLD;
            alu_q       <= ALU_PASS;
            clk_br_q    <= 1'b0;
            clk_flags_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            sdr_q       <= sdr_d;
            alu_q       <= alu_d;
            clk_br_q    <= clk_br_d;
            clk_flags_q <= clk_flags_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign sdr       = sdr_q;
    assign alu_fn    = alu_q;
    assign clk_br    = clk_br_q;
    assign clk_flags = clk_flags_q;
    assign count     = cnt_val;

endmodule
